fsic_wb_target_ctrl: RTL and testbench
======================================

Name: fsic_wb_target_ctrl

Overview:
- Sequences every management-SoC Wishbone slave access in the FSIC user area and routes it to one of NUM_TGT internal register targets (e.g. config block, AXI-lite bridge, IO serdes CSRs).
- Each target sees a request/acknowledge handshake.
- Accesses to invalid addresses, and targets that never answer, are terminated with an error pattern, so the SoC bus never hangs.
- Sits directly behind the top-level Wishbone slave port of FSIC.

Parameters:
- NUM_TGT, 4, number of targets; legal range 2..8.
- TIMEOUT, 64, number of WAIT cycles before forced termination; legal range 2..255.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an invalid-address or timeout access.

Ports:
- wb_clk  in  1  system clock; all logic is on its rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- wbs_adr  in  32  Wishbone address.
- wbs_wdata  in  32  Wishbone write data.
- wbs_sel  in  4  byte selects.
- wbs_cyc  in  1  bus cycle.
- wbs_stb  in  1  strobe.
- wbs_we  in  1  write enable.
- wbs_ack  out  1  one-cycle acknowledge, registered.
- wbs_rdata  out  32  read data, registered, valid while wbs_ack=1.
- tgt_req  out  NUM_TGT  one-hot request, held until acknowledge, timeout or abort.
- tgt_adr  out  12  latched wbs_adr[11:0].
- tgt_wdata  out  32  latched write data.
- tgt_sel  out  4  latched byte selects.
- tgt_we  out  1  latched write enable.
- tgt_ack  in  NUM_TGT  per-target acknowledge.
- tgt_rdata  in  NUM_TGT*32  per-target read data; target i occupies [32*i+:32].
- to_irq  out  1  one-cycle pulse on each timeout.
- to_cnt  out  8  timeout count, saturates at 255.

Behaviour:
- Reset: wb_rst is sampled on the wb_clk edge. It forces state=IDLE and drives all of the following to 0: tgt_req, wbs_ack, wbs_rdata, tgt_adr, tgt_wdata, tgt_sel, tgt_we, to_irq, to_cnt and the timeout counter. Reset in any state, including WAIT, drops tgt_req the next cycle and produces no wbs_ack.
- Address decode:
  - valid = (wbs_adr[31:16]==16'h3000) && (wbs_adr[15]==0) && (wbs_adr[14:12] < NUM_TGT).
  - idx = wbs_adr[14:12].
- States: IDLE, WAIT, RESP.
- IDLE:
  - On wbs_cyc & wbs_stb, latch adr[11:0], wdata, sel, we and idx into the tgt_* registers.
  - If the address is valid, go to WAIT with tgt_req[idx]=1 and the counter at 0.
  - If the address is invalid, go to RESP with wbs_rdata=ERR_DATA and no tgt_req. Invalid writes are dropped. Invalid accesses do not count as timeouts.
- WAIT, evaluated in this priority order each cycle:
  1. wbs_cyc==0: abort. Go to IDLE, tgt_req=0, no wbs_ack.
  2. tgt_ack[idx]==1: go to RESP with tgt_req=0. wbs_rdata = tgt_rdata[idx] on a read, 0 on a write.
  3. counter==TIMEOUT-1: go to RESP with wbs_rdata=ERR_DATA, tgt_req=0. to_irq pulses for 1 cycle, coincident with wbs_ack. to_cnt increments, saturating at 255.
  4. Otherwise the counter increments.
  - tgt_ack of non-selected targets is ignored in WAIT and in every other state.
  - An acknowledge arriving in the same cycle the counter reaches TIMEOUT-1 wins (rule 2 beats rule 3).
- RESP: wbs_ack=1 for exactly one cycle, then IDLE. wbs_rdata holds its value until the next RESP. wbs_ack is never high for two consecutive cycles.
- Latency, with wbs_cyc&wbs_stb first sampled high at edge N:
  - tgt_req is high from cycle N+1.
  - Target acknowledges in the first WAIT cycle: wbs_ack at cycle N+2.
  - Invalid address: wbs_ack at N+1.
  - Timeout: WAIT lasts exactly TIMEOUT cycles; wbs_ack at N+1+TIMEOUT.
- One access is outstanding at a time. A strobe during WAIT or RESP is not re-sampled. tgt_adr, tgt_wdata, tgt_sel and tgt_we stay stable from WAIT entry until the next IDLE acceptance.

Test Plan:
- Read, wbs_adr=0x3000_1004, target 1 acknowledges 3 cycles after tgt_req rises with tgt_rdata[63:32]=0x1234_5678 -> tgt_req=4'b0010 and tgt_adr=0x004; wbs_ack 1 cycle with wbs_rdata=0x1234_5678; tgt_req low in the ack cycle.
- Write, wbs_adr=0x3000_0010, wdata=0xA5A5_0001, sel=4'b0011, target 0 acknowledges immediately -> tgt_wdata, tgt_sel and tgt_we=1 stable; wbs_ack at N+2 with wbs_rdata=0.
- Invalid addresses 0x3000_8000 and 0x3001_0000 -> no tgt_req; wbs_ack at N+1 with wbs_rdata=0xDEAD_BEEF; to_cnt unchanged.
- Timeout, target 2 never acknowledges, TIMEOUT=64 -> wbs_ack at N+65 with 0xDEAD_BEEF; to_irq pulses once; to_cnt=1. A second access to target 3 then completes normally.
- Abort: wbs_cyc dropped 5 cycles into WAIT -> tgt_req low next cycle, no wbs_ack, to_cnt unchanged. Same-cycle case: tgt_ack rises exactly when the counter reaches 63 -> normal read data returned, no to_irq.
- Reset: wb_rst pulsed for 1 cycle during WAIT -> all outputs 0 the next cycle. 256 consecutive timeouts -> to_cnt saturates at 255.

Source files
------------

// File: rtl/fsic_wb_target_ctrl.sv
// fsic_wb_target_ctrl: sequences Wishbone slave accesses onto NUM_TGT req/ack register targets.
// Invalid addresses and silent targets end with ERR_DATA so the SoC bus never hangs.
module fsic_wb_target_ctrl #(
    parameter int          NUM_TGT  = 4,
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic [31:0]           wbs_adr,
    input  logic [31:0]           wbs_wdata,
    input  logic [3:0]            wbs_sel,
    input  logic                  wbs_cyc,
    input  logic                  wbs_stb,
    input  logic                  wbs_we,
    output logic                  wbs_ack,
    output logic [31:0]           wbs_rdata,
    output logic [NUM_TGT-1:0]    tgt_req,
    output logic [11:0]           tgt_adr,
    output logic [31:0]           tgt_wdata,
    output logic [3:0]            tgt_sel,
    output logic                  tgt_we,
    input  logic [NUM_TGT-1:0]    tgt_ack,
    input  logic [NUM_TGT*32-1:0] tgt_rdata,
    output logic                  to_irq,
    output logic [7:0]            to_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [7:0]  cnt;
    logic        valid;
    logic        ack_hit;
    logic [31:0] sel_rdata;
    assign valid   = (wbs_adr[31:16] == 16'h3000) && !wbs_adr[15] && (32'(wbs_adr[14:12]) < NUM_TGT);
    // tgt_req is one-hot on the latched index, so it doubles as the target select
    assign ack_hit = |(tgt_ack & tgt_req);
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_TGT; i++)
            sel_rdata = sel_rdata | (tgt_req[i] ? tgt_rdata[32*i+:32] : 32'd0);
    end
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state     <= IDLE;
            tgt_req   <= '0;
            wbs_ack   <= 1'b0;
            wbs_rdata <= '0;
            tgt_adr   <= '0;
            tgt_wdata <= '0;
            tgt_sel   <= '0;
            tgt_we    <= 1'b0;
            to_irq    <= 1'b0;
            to_cnt    <= '0;
            cnt       <= '0;
        end else begin
            wbs_ack <= 1'b0;
            to_irq  <= 1'b0;
            case (state)
                IDLE: if (wbs_cyc && wbs_stb) begin
                    tgt_adr   <= wbs_adr[11:0];
                    tgt_wdata <= wbs_wdata;
                    tgt_sel   <= wbs_sel;
                    tgt_we    <= wbs_we;
                    cnt       <= '0;
                    if (valid) begin
                        tgt_req <= NUM_TGT'(1) << wbs_adr[14:12];
                        state   <= WAIT;
                    end else begin
                        wbs_rdata <= ERR_DATA;
                        wbs_ack   <= 1'b1;
                        state     <= RESP;
                    end
                end
                WAIT: if (!wbs_cyc) begin
                    tgt_req <= '0;
                    state   <= IDLE;
                end else if (ack_hit) begin
                    tgt_req   <= '0;
                    wbs_rdata <= tgt_we ? 32'd0 : sel_rdata;
                    wbs_ack   <= 1'b1;
                    state     <= RESP;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    tgt_req   <= '0;
                    wbs_rdata <= ERR_DATA;
                    wbs_ack   <= 1'b1;
                    to_irq    <= 1'b1;
                    to_cnt    <= to_cnt + 8'(to_cnt != 8'hFF);
                    state     <= RESP;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsic_wb_target_ctrl.sv
// tb_fsic_wb_target_ctrl: directed plus randomized accesses checked against a transaction-level model.
module tb_fsic_wb_target_ctrl;
    localparam int          N   = 4;
    localparam int          TO  = 64;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     wbs_adr = '0, wbs_wdata = '0;
    logic [3:0]      wbs_sel = '0;
    logic            wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
    logic            wbs_ack;
    logic [31:0]     wbs_rdata;
    logic [N-1:0]    tgt_req;
    logic [11:0]     tgt_adr;
    logic [31:0]     tgt_wdata;
    logic [3:0]      tgt_sel;
    logic            tgt_we;
    logic [N-1:0]    tgt_ack = '0;
    logic [N*32-1:0] tgt_rdata = '0;
    logic            to_irq;
    logic [7:0]      to_cnt;
    int              checks = 0, errors = 0;
    int              exp_to = 0;
    always #5 clk = ~clk;
    fsic_wb_target_ctrl #(.NUM_TGT(N), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .wb_clk(clk), .wb_rst(rst), .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel),
        .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_ack(wbs_ack), .wbs_rdata(wbs_rdata),
        .tgt_req(tgt_req), .tgt_adr(tgt_adr), .tgt_wdata(tgt_wdata), .tgt_sel(tgt_sel), .tgt_we(tgt_we),
        .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata), .to_irq(to_irq), .to_cnt(to_cnt)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic bit is_valid(input logic [31:0] a);
        return a[31:16] == 16'h3000 && !a[15] && int'(a[14:12]) < N;
    endfunction
    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"}, 32'(wbs_ack), 0);
        chk({tag, "_req"}, 32'(tgt_req), 0);
        chk({tag, "_irq"}, 32'(to_irq), 0);
    endtask
    // d = WAIT cycle (0-based) in which the selected target acknowledges; d >= TO means never
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s, input logic w, input int d);
        int          idx = int'(a[14:12]);
        int          len;
        logic [31:0] exp_rd;
        wbs_adr = a; wbs_wdata = wd; wbs_sel = s; wbs_we = w;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; tgt_ack = '0;
        tick;
        if (!is_valid(a)) begin
            chk("inv_req", 32'(tgt_req), 0);
            chk("inv_ack", 32'(wbs_ack), 1);
            chk("inv_rdata", wbs_rdata, ERR);
            chk("inv_to_cnt", 32'(to_cnt), 32'(exp_to));
            chk("inv_irq", 32'(to_irq), 0);
        end else begin
            chk("req_onehot", 32'(tgt_req), 32'(1) << idx);
            chk("tgt_adr", 32'(tgt_adr), 32'(a[11:0]));
            chk("tgt_wdata", tgt_wdata, wd);
            chk("tgt_sel", 32'(tgt_sel), 32'(s));
            chk("tgt_we", 32'(tgt_we), 32'(w));
            len = (d < TO) ? d + 1 : TO;
            exp_rd = (d < TO) ? 32'd0 : ERR;
            for (int k = 0; k < len; k++) begin
                chk("wait_req", 32'(tgt_req), 32'(1) << idx);
                chk("wait_ack", 32'(wbs_ack), 0);
                tgt_ack = N'($urandom);
                tgt_ack[idx] = (k == d);
                for (int i = 0; i < N; i++) tgt_rdata[32*i+:32] = $urandom;
                if (k == d && !w) exp_rd = tgt_rdata[32*idx+:32];
                tick;
            end
            if (d >= TO) exp_to = (exp_to < 255) ? exp_to + 1 : 255;
            chk("resp_ack", 32'(wbs_ack), 1);
            chk("resp_rdata", wbs_rdata, exp_rd);
            chk("resp_req", 32'(tgt_req), 0);
            chk("resp_irq", 32'(to_irq), (d >= TO) ? 32'd1 : 32'd0);
            chk("resp_to_cnt", 32'(to_cnt), 32'(exp_to));
            chk("hold_adr", 32'(tgt_adr), 32'(a[11:0]));
            chk("hold_wdata", tgt_wdata, wd);
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0; tgt_ack = '0;
        tick;
        chk_idle_outputs("post");
        chk("post_rdata_hold", wbs_rdata, exp_rd_or(a, wbs_rdata));
    endtask
    // rdata must hold after RESP; for invalid accesses the held value is ERR
    function automatic logic [31:0] exp_rd_or(input logic [31:0] a, input logic [31:0] cur);
        return is_valid(a) ? cur : ERR;
    endfunction
    task automatic abort_access(input int tgt, input int at);
        logic [31:0] rd_before = wbs_rdata;
        wbs_adr = {16'h3000, 1'b0, 3'(tgt), 12'h020}; wbs_we = 1'b0;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; tgt_ack = '0;
        tick;
        for (int k = 0; k < at; k++) begin
            chk("abort_wait_req", 32'(tgt_req), 32'(1) << tgt);
            tick;
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        tick;
        chk_idle_outputs("abort");
        chk("abort_rdata_hold", wbs_rdata, rd_before);
        tick;
        chk("abort_ack2", 32'(wbs_ack), 0);
        chk("abort_to_cnt", 32'(to_cnt), 32'(exp_to));
    endtask
    initial begin
        logic [31:0] a;
        int d;
        tick; tick;
        rst = 1'b0;
        chk_idle_outputs("reset");
        chk("reset_rdata", wbs_rdata, 0);
        chk("reset_to_cnt", 32'(to_cnt), 0);
        chk("reset_adr", 32'(tgt_adr), 0);
        access(32'h3000_1004, 32'h0, 4'hF, 1'b0, 3);
        access(32'h3000_0010, 32'hA5A5_0001, 4'b0011, 1'b1, 0);
        access(32'h3000_8000, 32'h1111_2222, 4'hF, 1'b1, 0);
        access(32'h3001_0000, 32'h0, 4'hF, 1'b0, 0);
        access(32'h3000_2100, 32'h0, 4'hF, 1'b0, 1000);
        access(32'h3000_3008, 32'h0, 4'hF, 1'b0, 2);
        abort_access(1, 5);
        access(32'h3000_200C, 32'h0, 4'hF, 1'b0, TO - 1);
        // reset mid-WAIT
        wbs_adr = 32'h3000_3000; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0; exp_to = 0;
        chk_idle_outputs("wait_reset");
        chk("wait_reset_rdata", wbs_rdata, 0);
        chk("wait_reset_to_cnt", 32'(to_cnt), 0);
        chk("wait_reset_we", 32'(tgt_we), 0);
        tick;
        chk("wait_reset_ack2", 32'(wbs_ack), 0);
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                4:       a = {16'h3000 ^ 16'($urandom_range(1, 65535)), 16'($urandom)};
                5:       a = {16'h3000, 1'b1, 15'($urandom)};
                default: a = {16'h3000, 1'b0, 3'($urandom_range(0, N - 1)), 12'($urandom)};
            endcase
            if ($urandom_range(0, 9) == 0) a = {16'h3000, 1'b0, 3'($urandom_range(N, 7)), 12'($urandom)};
            case ($urandom_range(0, 9))
                0:       d = TO - 1;
                1:       d = TO + 5;
                default: d = $urandom_range(0, 6);
            endcase
            access(a, $urandom, 4'($urandom), 1'($urandom), d);
        end
        for (int n = 0; n < 256; n++)
            access({16'h3000, 1'b0, 3'(n % N), 12'h100}, 32'h0, 4'hF, 1'b0, TO);
        chk("sat_to_cnt", 32'(to_cnt), 255);
        access(32'h3000_0ABC, 32'h0, 4'hF, 1'b0, TO);
        chk("sat_to_cnt_hold", 32'(to_cnt), 255);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
